// File: rtl/data_mem_stage.sv
// ---------------------------------------------------------------------------
// data_mem_stage
//
// This is the data-memory (DM) stage of the 8-bit MIPS-style pipeline. It
// sits between the EX and WB stages.
//
// The EX-stage ALU result (ans_ex) is used as a byte address into a
// 2**ADDR_W-entry RAM. The stage can store one byte to that address or load
// one byte from it. For ops that do not touch memory, ans_ex is passed
// through unchanged. The selected value is registered into ans_dm for
// writeback, so the stage has one cycle of latency.
//
// Ports:
//   clk            - system clock; all state updates on the rising edge
//   reset          - synchronous, active-high; clears ans_dm and every RAM word
//   ans_ex         - EX result: memory address, or the passthrough value
//   DM_data        - store data forwarded from EX
//   mem_rw_ex      - 1 = store, 0 = load
//   mem_en_ex      - 1 = memory access this cycle
//   mem_mux_sel_dm - 1 = register the memory read path, 0 = register ans_ex
//   ans_dm         - registered stage result to writeback
//
// Optional build macro:
//   DM_STORE_ECHO_EN - when defined, a store cycle with mem_mux_sel_dm=1
//                      registers DM_data into ans_dm. This makes the stored
//                      byte visible for debug and forwarding. When the macro
//                      is not defined, ans_dm receives 0x00 in that case.
// ---------------------------------------------------------------------------
module data_mem_stage #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] ans_ex,
    input  logic [DATA_W-1:0] DM_data,
    input  logic              mem_rw_ex,
    input  logic              mem_en_ex,
    input  logic              mem_mux_sel_dm,
    output logic [DATA_W-1:0] ans_dm
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] addr;
    logic              store_cycle;
    logic              load_cycle;
    logic [DATA_W-1:0] rd;
    logic [DATA_W-1:0] ans_next;

    assign addr        = ans_ex[ADDR_W-1:0];
    assign store_cycle = mem_en_ex &  mem_rw_ex;
    assign load_cycle  = mem_en_ex & ~mem_rw_ex;

    // Read data is combinational. It reads 0x00 whenever no load is
    // requested, so a store or an idle cycle on the memory path gives zero.
    always_comb begin
        rd = '0;
        if (load_cycle) begin
            rd = mem[addr];
        end
    end

    // Select what the writeback stage sees next. On a store with the memory
    // path selected, the echo build forwards the store data in place of
    // the zero read.
    always_comb begin
        ans_next = ans_ex;
        if (mem_mux_sel_dm) begin
`ifdef DM_STORE_ECHO_EN
            if (store_cycle) begin
                ans_next = DM_data;
            end else begin
                ans_next = rd;
            end
`else
            ans_next = rd;
`endif
        end
    end

    // Reset clears the entire RAM and takes priority over a store in the
    // same cycle. A store completes at the edge, so a load issued in the
    // following cycle already sees the new value.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (store_cycle) begin
            mem[addr] <= DM_data;
        end
    end

    // Stage output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            ans_dm <= '0;
        end else begin
            ans_dm <= ans_next;
        end
    end

endmodule

// File: tb/tb_data_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_data_mem_stage
//
// This bench applies directed vectors to data_mem_stage.
//
// A byte-array model of the RAM predicts the registered result for every
// cycle, and a negedge process compares ans_dm against that prediction.
// Hand-computed literals taken from the expected stage behaviour pin the
// model itself.
// ---------------------------------------------------------------------------
module tb_data_mem_stage;

    logic       clk;
    logic       reset;
    logic [7:0] ans_ex;
    logic [7:0] DM_data;
    logic       mem_rw_ex;
    logic       mem_en_ex;
    logic       mem_mux_sel_dm;
    logic [7:0] ans_dm;

    int checks   = 0;
    int failures = 0;

    logic [7:0] model_mem [256];
    logic [7:0] model_ans;
    bit         model_valid = 0;

    // Value ans_dm must hold after a store with the memory path selected.
`ifdef DM_STORE_ECHO_EN
    localparam bit ECHO = 1'b1;
`else
    localparam bit ECHO = 1'b0;
`endif

    data_mem_stage dut (
        .clk            (clk),
        .reset          (reset),
        .ans_ex         (ans_ex),
        .DM_data        (DM_data),
        .mem_rw_ex      (mem_rw_ex),
        .mem_en_ex      (mem_en_ex),
        .mem_mux_sel_dm (mem_mux_sel_dm),
        .ans_dm         (ans_dm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare the DUT against the model once per cycle, away from the
    // rising edge.
    always @(negedge clk) begin
        if (model_valid) begin
            checks++;
            if (ans_dm !== model_ans) begin
                failures++;
                $display("[TB] FAIL per_cycle: ans_dm=0x%02h model=0x%02h at %0t",
                         ans_dm, model_ans, $time);
            end
        end
    end

    // Drive one cycle of inputs. Predict the registered result from the
    // stage rules, then advance the model across the rising edge.
    task automatic applyStimulus(input logic rst, input logic [7:0] a,
                                 input logic [7:0] d, input logic rw,
                                 input logic en, input logic sel);
        logic [7:0] exp;
        reset          = rst;
        ans_ex         = a;
        DM_data        = d;
        mem_rw_ex      = rw;
        mem_en_ex      = en;
        mem_mux_sel_dm = sel;
        if (rst)               exp = 8'h00;
        else if (!sel)         exp = a;
        else if (en && !rw)    exp = model_mem[a];
        else if (en && rw)     exp = ECHO ? d : 8'h00;
        else                   exp = 8'h00;
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;
        end else if (en && rw) begin
            model_mem[a] = d;
        end
        model_ans   = exp;
        model_valid = 1'b1;
        #1;
    endtask

    // Check ans_dm against a hand-computed literal.
    task automatic checkOutput(input string name, input logic [7:0] expected);
        checks++;
        if (ans_dm !== expected) begin
            failures++;
            $display("[TB] FAIL %s: ans_dm=0x%02h expected=0x%02h", name, ans_dm, expected);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) model_mem[i] = 8'hXX;
        reset = 1'b1; ans_ex = 8'h00; DM_data = 8'h00;
        mem_rw_ex = 1'b0; mem_en_ex = 1'b0; mem_mux_sel_dm = 1'b0;

        // Reset for two cycles while a store to 0x03 is presented.
        applyStimulus(1, 8'h03, 8'h5A, 1, 1, 0);
        checkOutput("reset_cycle1", 8'h00);
        applyStimulus(1, 8'h03, 8'h5A, 1, 1, 1);
        checkOutput("reset_cycle2", 8'h00);
        applyStimulus(0, 8'h03, 8'h00, 0, 1, 1);
        checkOutput("load_after_reset", 8'h00);

        // Passthrough, including one cycle with a load requested that must
        // be ignored because the memory path is not selected.
        applyStimulus(0, 8'h03, 8'h00, 0, 0, 0);
        checkOutput("passthrough", 8'h03);
        applyStimulus(0, 8'hC7, 8'h00, 0, 1, 0);
        checkOutput("passthrough_load_ignored", 8'hC7);

        // Store followed by a load from the same address.
        applyStimulus(0, 8'h03, 8'hFF, 1, 1, 1);
        checkOutput("store_cycle_out", ECHO ? 8'hFF : 8'h00);
        applyStimulus(0, 8'h03, 8'h00, 0, 1, 1);
        checkOutput("load_after_store", 8'hFF);
        applyStimulus(0, 8'h03, 8'h00, 0, 0, 1);
        checkOutput("sel_mem_no_enable", 8'h00);

        // A store with the enable low must not write.
        applyStimulus(0, 8'h05, 8'hAA, 1, 0, 1);
        checkOutput("blocked_store_out", 8'h00);
        applyStimulus(0, 8'h05, 8'h00, 0, 1, 1);
        checkOutput("blocked_store_load", 8'h00);

        // Address boundaries and their neighbours.
        applyStimulus(0, 8'h00, 8'h11, 1, 1, 0);
        checkOutput("store_pass_addr", 8'h00);
        applyStimulus(0, 8'hFF, 8'h22, 1, 1, 1);
        applyStimulus(0, 8'h00, 8'h00, 0, 1, 1);
        checkOutput("load_addr_00", 8'h11);
        applyStimulus(0, 8'hFF, 8'h00, 0, 1, 1);
        checkOutput("load_addr_ff", 8'h22);
        applyStimulus(0, 8'h01, 8'h00, 0, 1, 1);
        checkOutput("load_addr_01", 8'h00);
        applyStimulus(0, 8'hFE, 8'h00, 0, 1, 1);
        checkOutput("load_addr_fe", 8'h00);

        // Scattered store/load sweep. Only the model checks these cycles.
        for (int i = 0; i < 8; i++)
            applyStimulus(0, 8'(i * 37 + 9), 8'(i * 29 + 8'h40), 1, 1, i[0]);
        for (int i = 7; i >= 0; i--)
            applyStimulus(0, 8'(i * 37 + 9), 8'h00, 0, 1, 1);
        applyStimulus(0, 8'd46, 8'h00, 0, 1, 1);
        checkOutput("sweep_addr_46", 8'h5D);

        // Reset during a store must win, and it must clear earlier data.
        applyStimulus(0, 8'h03, 8'hFF, 1, 1, 1);
        applyStimulus(1, 8'h04, 8'h77, 1, 1, 1);
        checkOutput("reset_mid_op", 8'h00);
        applyStimulus(0, 8'h03, 8'h00, 0, 1, 1);
        checkOutput("load_03_after_reset", 8'h00);
        applyStimulus(0, 8'h04, 8'h00, 0, 1, 1);
        checkOutput("load_04_after_reset", 8'h00);

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_mem_stage.md
Name: data_mem_stage

Overview:
- Data-memory (DM) pipeline stage of the 8-bit MIPS-style processor; sits between the EX and WB stages.
- Takes the EX-stage ALU result `ans_ex` as an address and stores or loads one byte of a 256-entry RAM.
- Registers either the loaded byte or `ans_ex` itself into `ans_dm` for the writeback stage.

Parameters:
- DATA_W, 8, width of data bus and memory word.
- ADDR_W, 8, address width; memory depth is 2**ADDR_W (256 words).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- ans_ex  input  DATA_W  EX-stage ALU result; memory address for load/store, passthrough value for non-memory ops.
- DM_data  input  DATA_W  store data (register operand forwarded from EX).
- mem_rw_ex  input  1  access direction: 1 = write (store), 0 = read (load).
- mem_en_ex  input  1  memory access enable; 0 = no memory access this cycle.
- mem_mux_sel_dm  input  1  output select: 1 = memory read path, 0 = ans_ex passthrough.
- ans_dm  output  DATA_W  registered stage result to writeback.

Behaviour:
- One clock; reset is synchronous and active-high; clock port `clk`, reset port `reset`.
- Reset (rising clk with reset=1):
  - ans_dm <= 0x00.
  - All 256 memory words <= 0x00.
  - Reset has priority over any write or read in the same cycle.
- Write: on rising clk with reset=0, mem_en_ex=1 and mem_rw_ex=1, mem[ans_ex[ADDR_W-1:0]] <= DM_data.
  - No write under any other condition.
- Read data (combinational internal signal rd):
  - rd = mem[ans_ex] when mem_en_ex=1 and mem_rw_ex=0.
  - rd = 0x00 otherwise.
- Output register, on rising clk with reset=0:
  - ans_dm <= rd when mem_mux_sel_dm=1.
  - ans_dm <= ans_ex when mem_mux_sel_dm=0.
- Latency: 1 cycle. The input sampled at edge N appears on ans_dm after edge N.
- A load issued the cycle after a store to the same address returns the stored value (the write is complete at the edge).
- Read and write cannot coincide because mem_rw_ex selects one.
- Full 8-bit address range 0x00–0xFF is valid; no wrap or out-of-range case.
- During a store with mem_mux_sel_dm=1, ans_dm <= 0x00 (see optional feature).
- No handshake and no stall; one operation per cycle.
- X on control inputs is undefined; the bench shall keep controls driven.

Optional Feature:
- Macro: DM_STORE_ECHO_EN.
- Defined: during a store cycle (en=1, rw=1) with mem_mux_sel_dm=1, ans_dm <= DM_data, so the stored byte is visible for debug/forwarding.
- Undefined: ans_dm <= 0x00 in that case, per Behaviour.
- All other behaviour is identical with or without the macro.

Test Plan:
- reset=1 for 2 cycles, any inputs -> ans_dm=0x00; a later read of addr 0x03 returns 0x00.
- reset=0, mem_mux_sel_dm=0, en=0, ans_ex=0x03 -> ans_dm=0x03 after the next rising edge.
- Store: en=1, rw=1, ans_ex=0x03, DM_data=0xFF, sel=1 for 1 cycle, then load en=1, rw=0, sel=1 -> ans_dm=0xFF one edge after the load is sampled. During the store cycle ans_dm=0x00, or 0xFF with DM_STORE_ECHO_EN.
- Store blocked: en=0, rw=1, ans_ex=0x05, DM_data=0xAA, then load addr 0x05 -> ans_dm=0x00.
- Boundaries: store 0x11 at 0x00 and 0x22 at 0xFF, load both -> 0x11 and 0x22; neighbour addresses 0x01 and 0xFE stay 0x00.
- Reset mid-operation: after storing 0xFF at 0x03, assert reset=1 on a store cycle to 0x04, then load 0x03 and 0x04 -> both 0x00 and ans_dm=0x00 during reset.
